// File: rtl/shift_right_sequencer_pkg.sv
// Shared types and constants for the multi-cycle right-shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // Width and largest amount the single-cycle step unit can shift.
  localparam int STEP_W   = 3;
  localparam int STEP_MAX = 7;

endpackage

// File: rtl/shift_right_sequencer_if.sv
// Request/response bundle between a requester and the shift sequencer.
//
// Handshake: the requester may raise start in any cycle; it is taken on the
// rising clk edge only while busy=0 (a and amount are captured on that same
// edge). While busy=1, start, a and amount are ignored. Completion is a
// one-cycle done pulse; result is valid from that cycle and held until the
// next completion. state mirrors the controller FSM for observation only.
interface shift_right_sequencer_if
  import shift_seq_pkg::*;
#(
  parameter int N     = 16,
  parameter int AMT_W = 5
);
  logic             start;
  logic [N-1:0]     a;
  logic [AMT_W-1:0] amount;
  logic             busy;
  logic             done;
  logic [N-1:0]     result;
  state_t           state;

  modport master (
    output start, a, amount,
    input  busy, done, result, state
  );

  modport slave (
    input  start, a, amount,
    output busy, done, result, state
  );
endinterface

// File: rtl/shift_right_sequencer_shr_step.sv
// Combinational logical right shift by 0..STEP_MAX with zero fill.
module shr_step
  import shift_seq_pkg::*;
#(
  parameter int N = 16
) (
  input  logic [N-1:0]      x,
  input  logic [STEP_W-1:0] sh,
  output logic [N-1:0]      y
);

  assign y = x >> sh;

endmodule

// File: rtl/shift_right_sequencer.sv
// Iterates a 0..7 step shifter over an accumulator until the requested
// total right-shift amount is consumed, then pulses done with the result.
module shift_right_sequencer
  import shift_seq_pkg::*;
#(
  parameter int N     = 16,
  parameter int AMT_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_right_sequencer_if.slave bus
);

  state_t            state;
  state_t            state_next;
  logic [N-1:0]      acc;
  logic [N-1:0]      acc_shr;
  logic [N-1:0]      result;
  logic [AMT_W-1:0]  remaining;
  logic [STEP_W-1:0] step;
  logic              accept;
  logic              last_step;

  // A request is taken whenever no shift steps are in flight.
  assign accept = bus.start && (state != S_SHIFT);

  // Step is min(remaining, STEP_MAX); the final step consumes exactly what is left.
  assign step      = (remaining > AMT_W'(STEP_MAX)) ? STEP_W'(STEP_MAX)
                                                    : STEP_W'(remaining);
  assign last_step = (remaining == AMT_W'(step));

  shr_step #(.N(N)) u_step (
    .x  (acc),
    .sh (step),
    .y  (acc_shr)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept)              state_next = (bus.amount != '0) ? S_SHIFT : S_DONE;
        else if (state == S_DONE) state_next = S_IDLE;
      end
      S_SHIFT: begin
        if (last_step) state_next = S_DONE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: capture on accept, step while shifting, publish result on the last step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      remaining <= '0;
      result    <= '0;
    end else if (accept) begin
      acc       <= bus.a;
      remaining <= bus.amount;
      if (bus.amount == '0) result <= bus.a;
    end else if (state == S_SHIFT) begin
      acc       <= acc_shr;
      remaining <= remaining - AMT_W'(step);
      if (last_step) result <= acc_shr;
    end
  end

  assign bus.busy   = (state == S_SHIFT);
  assign bus.done   = (state == S_DONE);
  assign bus.result = result;
  assign bus.state  = state;

endmodule

// File: doc/shift_right_sequencer.md
Name: shift_right_sequencer

Overview:
Multi-cycle controller that performs logical right shifts wider than a single 3-bit (0..7) shift step can cover.
- Latches an operand and a total shift amount.
- Drives a combinational 0..7 logical right-shift step unit repeatedly, one step per clock, until the amount is consumed.
- Presents the result with a one-cycle done pulse.
- Sits between a requester (e.g. ALU control or test FSM) and the shift datapath.

Parameters:
- N, 16, operand/result width in bits.
- AMT_W, 5, width of the total shift amount (max amount 2^AMT_W-1).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  request pulse; sampled only when busy=0.
- a  in  N  operand; captured on the accepted start edge.
- amount  in  AMT_W  total right-shift amount; captured with a.
- busy  out  1  high while shift steps are in progress.
- done  out  1  one-cycle pulse; result valid from this cycle.
- result  out  N  last completed result; held until the next completion.

Behaviour:
- Clock/reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state=S_IDLE, acc=0, remaining=0, result=0, busy=0, done=0. Assertion mid-operation aborts immediately; no done is issued for the aborted op.
- States: S_IDLE, S_SHIFT, S_DONE.
- Start acceptance: accept start when state is S_IDLE or S_DONE (busy=0). On the accepted edge, acc<=a and remaining<=amount.
  - Next state is S_SHIFT if amount!=0.
  - Otherwise next state is S_DONE with result<=a.
- S_SHIFT, each cycle:
  - step = min(remaining, 7), a 3-bit value.
  - acc <= acc >> step, logical with zero fill.
  - remaining <= remaining - step.
  - If remaining == step: next state S_DONE and result <= acc >> step. Otherwise stay in S_SHIFT.
- S_DONE: done=1 for exactly one cycle. Next state is S_SHIFT or S_DONE if start is accepted, else S_IDLE.
- Outputs: busy = (state==S_SHIFT). done = (state==S_DONE). Both are registered-state decodes, glitch-free.
- Latency: start high in cycle 0. k = ceil(amount/7) shift cycles.
  - busy is high in cycles 1..k.
  - done is high in cycle k+1.
  - amount=0 gives done in cycle 1 with busy never asserted.
- Back-to-back throughput: a new start accepted in the S_DONE cycle yields done again k+1 cycles later. The previous result is held until then.
- start while busy=1 is ignored. a and amount are don't-care while busy.
- amount >= N: iteration still runs the full k steps; result=0.
- result changes only on the S_DONE entry edge. It never shows intermediate acc values.
- Width rule: remaining is AMT_W bits. The subtraction never underflows because step <= remaining.

Decomposition:
- Package shift_seq_pkg:
  - typedef enum logic [1:0] state_t {S_IDLE, S_SHIFT, S_DONE}.
  - localparam STEP_W=3.
  - localparam STEP_MAX=7.
- One sub-module: shr_step, combinational N-bit logical right shift by a STEP_W-bit amount. Instantiated once on acc.
- The FSM, acc/remaining/result registers and min() step select live in shift_right_sequencer.

Test Plan (N=16, AMT_W=5):
- a=16'hF0F0, amount=4, start in cycle 0 -> busy cycle 1 only, done cycle 2, result=16'h0F0F.
- a=16'h1234, amount=0 -> busy never high, done cycle 1, result=16'h1234.
- a=16'h8000, amount=15 (steps 7,7,1) -> busy cycles 1-3, done cycle 4, result=16'h0001.
- a=16'hFFFF, amount=31 -> 5 shift cycles, done cycle 6, result=16'h0000.
- start with a=16'hAAAA pulsed during busy of the 16'h8000/15 op -> ignored, result=16'h0001. Then start a=16'h00F0, amount=4 in that op's done cycle -> accepted, next done 2 cycles later, result=16'h000F.
- rst pulsed in cycle 2 of the amount=15 op -> busy/done/result drop to 0 asynchronously, no done pulse. A following a=16'h0100, amount=8 op completes normally with result=16'h0001.
